// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encoding and size defaults for the ALU command sequencer.
package alu_seq_pkg;

  localparam int DW_DEF   = 16;
  localparam int NREG_DEF = 8;

  localparam logic [2:0] OP_NEG  = 3'b000;
  localparam logic [2:0] OP_INC  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_AVG  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_PASS = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_WB    = 2'd3
  } state_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Host-side bundle: command handshake, host register write port and architectural status.
interface alu_cmd_sequencer_if #(
  parameter int DW = 16
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [2:0]    cmd_ra;
  logic [2:0]    cmd_rb;
  logic [2:0]    cmd_rd;
  logic          cmd_use_c;
  logic          wr_en;
  logic [2:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_err;
  logic          done;
  logic          op_err;
  logic [DW-1:0] result;
  logic          flag_z;
  logic          flag_n;
  logic          flag_c;

  modport master (
    output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_use_c,
    output wr_en, wr_addr, wr_data,
    input  cmd_ready, wr_err, done, op_err, result, flag_z, flag_n, flag_c
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_use_c,
    input  wr_en, wr_addr, wr_data,
    output cmd_ready, wr_err, done, op_err, result, flag_z, flag_n, flag_c
  );
endinterface

// File: rtl/alu_seq_regfile.sv
// NREG x DW register file: two asynchronous read ports, one write port, r0 reads as zero.
module alu_seq_regfile #(
  parameter int DW   = 16,
  parameter int NREG = 8,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra_addr,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] ra_data,
  output logic [DW-1:0] rb_data,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata
);

  logic [DW-1:0] mem [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign ra_data = (ra_addr == '0) ? '0 : mem[ra_addr];
  assign rb_data = (rb_addr == '0) ? '0 : mem[rb_addr];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Multi-cycle command driver for the combinational datapath ALU: fetch operands, execute,
// then write back result and Z/N/C flags, one command every four cycles.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int NREG = NREG_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_cmd_sequencer_if.slave  bus,
  output logic [DW-1:0]       alu_a,
  output logic [DW-1:0]       alu_b,
  output logic                alu_c,
  output logic [2:0]          alu_opc,
  input  logic [DW-1:0]       alu_w,
  input  logic                alu_zer,
  input  logic                alu_neg
);

  localparam int AW = $clog2(NREG);

  state_t        state;
  logic [2:0]    op_q;
  logic [AW-1:0] ra_q;
  logic [AW-1:0] rb_q;
  logic [AW-1:0] rd_q;
  logic          use_c_q;
  logic [DW-1:0] w_q;
  logic          zer_q;
  logic          neg_q;
  logic          cry_q;

  logic [DW-1:0] rdata_a;
  logic [DW-1:0] rdata_b;
  logic          host_we;
  logic          wb_we;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  function automatic logic carry_out(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                     input logic cin);
    logic [DW:0] sum;
    sum = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
    return sum[DW];
  endfunction

  // The host owns the write port only while idle; otherwise it belongs to writeback.
  assign host_we  = bus.wr_en && (state == S_IDLE);
  assign wb_we    = (state == S_WB) && (op_q != OP_ILL);
  assign rf_we    = host_we || wb_we;
  assign rf_waddr = wb_we ? rd_q : bus.wr_addr[AW-1:0];
  assign rf_wdata = wb_we ? w_q : bus.wr_data;
  assign bus.wr_err = bus.wr_en && (state != S_IDLE);

  alu_seq_regfile #(
    .DW   (DW),
    .NREG (NREG),
    .AW   (AW)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (ra_q),
    .rb_addr (rb_q),
    .ra_data (rdata_a),
    .rb_data (rdata_b),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      bus.cmd_ready <= 1'b1;
      bus.done      <= 1'b0;
      bus.op_err    <= 1'b0;
      bus.result    <= '0;
      bus.flag_z    <= 1'b0;
      bus.flag_n    <= 1'b0;
      bus.flag_c    <= 1'b0;
      op_q          <= '0;
      ra_q          <= '0;
      rb_q          <= '0;
      rd_q          <= '0;
      use_c_q       <= 1'b0;
      w_q           <= '0;
      zer_q         <= 1'b0;
      neg_q         <= 1'b0;
      cry_q         <= 1'b0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_c         <= 1'b0;
      alu_opc       <= '0;
    end else begin
      bus.done   <= 1'b0;
      bus.op_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            op_q          <= bus.cmd_op;
            ra_q          <= bus.cmd_ra[AW-1:0];
            rb_q          <= bus.cmd_rb[AW-1:0];
            rd_q          <= bus.cmd_rd[AW-1:0];
            use_c_q       <= bus.cmd_use_c;
            bus.cmd_ready <= 1'b0;
            state         <= S_FETCH;
          end
        end
        // Operands are read here, after any same-edge host write has landed.
        S_FETCH: begin
          alu_a   <= rdata_a;
          alu_b   <= rdata_b;
          alu_opc <= op_q;
          alu_c   <= use_c_q && bus.flag_c && (op_q == OP_ADD);
          state   <= S_EXEC;
        end
        S_EXEC: begin
          w_q        <= alu_w;
          zer_q      <= alu_zer;
          neg_q      <= alu_neg;
          cry_q      <= carry_out(alu_a, alu_b, alu_c);
          bus.done   <= 1'b1;
          bus.op_err <= (op_q == OP_ILL);
          state      <= S_WB;
        end
        S_WB: begin
          if (op_q != OP_ILL) begin
            bus.result <= w_q;
            bus.flag_z <= zer_q;
            bus.flag_n <= neg_q;
            if (op_q == OP_ADD) bus.flag_c <= cry_q;
          end
          bus.cmd_ready <= 1'b1;
          state         <= S_IDLE;
        end
        default: begin
          bus.cmd_ready <= 1'b1;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench: sequencer plus a behavioural 16-bit ALU, expectations written by hand.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_c;
  logic [2:0]  alu_opc;
  logic [15:0] alu_w;
  logic        alu_zer;
  logic        alu_neg;
  logic [16:0] s17;

  int errors = 0;
  int checks = 0;
  int lat;
  logic oe;

  alu_cmd_sequencer_if #(.DW(16)) bus ();

  alu_cmd_sequencer #(.DW(16), .NREG(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_c   (alu_c),
    .alu_opc (alu_opc),
    .alu_w   (alu_w),
    .alu_zer (alu_zer),
    .alu_neg (alu_neg)
  );

  always #5 clk = ~clk;

  always_comb begin
    s17 = {1'b0, alu_a} + {1'b0, alu_b};
    case (alu_opc)
      3'b000:  alu_w = 16'd0 - alu_a;
      3'b001:  alu_w = alu_a + 16'd1;
      3'b010:  alu_w = alu_a + alu_b + {15'd0, alu_c};
      3'b011:  alu_w = s17[16:1];
      3'b100:  alu_w = alu_a & alu_b;
      3'b101:  alu_w = alu_a | alu_b;
      3'b110:  alu_w = alu_a;
      default: alu_w = 16'h0000;
    endcase
  end
  assign alu_zer = (alu_w == 16'h0000);
  assign alu_neg = alu_w[15];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_reg(input logic [2:0] addr, input logic [15:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    @(posedge clk); #1;
    bus.wr_en   = 1'b0;
  endtask

  task automatic start_cmd(input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb,
                           input logic [2:0] rd, input logic uc);
    bus.cmd_op    = op;
    bus.cmd_ra    = ra;
    bus.cmd_rb    = rb;
    bus.cmd_rd    = rd;
    bus.cmd_use_c = uc;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic finish_cmd(input int lat0, output int lat_o, output logic oe_o);
    lat_o = lat0;
    oe_o  = 1'b0;
    while (bus.done !== 1'b1 && lat_o < 12) begin
      @(posedge clk); #1;
      lat_o++;
    end
    oe_o = bus.op_err;
    @(posedge clk); #1;
  endtask

  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [2:0] ra,
                         input logic [2:0] rb, input logic [2:0] rd, input logic uc);
    start_cmd(op, ra, rb, rd, uc);
    finish_cmd(1, lat, oe);
    chk({tag, "_latency"}, lat, 3);
    chk({tag, "_op_err"}, oe, (op == 3'b111));
    chk({tag, "_ready_back"}, bus.cmd_ready, 1'b1);
    chk({tag, "_done_pulse"}, bus.done, 1'b0);
  endtask

  task automatic chk_flags(input string tag, input logic [15:0] res, input logic z,
                           input logic n, input logic c);
    chk({tag, "_result"}, bus.result, res);
    chk({tag, "_z"}, bus.flag_z, z);
    chk({tag, "_n"}, bus.flag_n, n);
    chk({tag, "_c"}, bus.flag_c, c);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'b000;
    bus.cmd_ra    = 3'd0;
    bus.cmd_rb    = 3'd0;
    bus.cmd_rd    = 3'd0;
    bus.cmd_use_c = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = 3'd0;
    bus.wr_data   = 16'h0000;

    #12;
    chk("rst_ready", bus.cmd_ready, 1'b1);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_op_err", bus.op_err, 1'b0);
    chk("rst_wr_err", bus.wr_err, 1'b0);
    chk("rst_alu_a", alu_a, 16'h0000);
    chk("rst_alu_opc", alu_opc, 3'b000);
    chk_flags("rst", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    wr_reg(3'd1, 16'd5);
    wr_reg(3'd2, 16'd7);
    run_cmd("add", 3'b010, 3'd1, 3'd2, 3'd3, 1'b0);
    chk_flags("add", 16'h000C, 1'b0, 1'b0, 1'b0);

    wr_reg(3'd1, 16'd1);
    run_cmd("neg", 3'b000, 3'd1, 3'd0, 3'd4, 1'b0);
    chk_flags("neg", 16'hFFFF, 1'b0, 1'b1, 1'b0);

    run_cmd("ill", 3'b111, 3'd1, 3'd2, 3'd3, 1'b0);
    chk_flags("ill", 16'hFFFF, 1'b0, 1'b1, 1'b0);
    run_cmd("ill_r3", 3'b110, 3'd3, 3'd0, 3'd7, 1'b0);
    chk("ill_r3_kept", bus.result, 16'h000C);

    wr_reg(3'd1, 16'hFFFF);
    wr_reg(3'd2, 16'h0001);
    run_cmd("addc", 3'b010, 3'd1, 3'd2, 3'd5, 1'b0);
    chk_flags("addc", 16'h0000, 1'b1, 1'b0, 1'b1);
    run_cmd("inc", 3'b001, 3'd2, 3'd0, 3'd7, 1'b0);
    chk_flags("inc_c_held", 16'h0002, 1'b0, 1'b0, 1'b1);
    run_cmd("cin", 3'b010, 3'd0, 3'd0, 3'd6, 1'b1);
    chk_flags("cin", 16'h0001, 1'b0, 1'b0, 1'b0);
    run_cmd("r5", 3'b110, 3'd5, 3'd0, 3'd7, 1'b0);
    chk("r5_zero", bus.result, 16'h0000);

    // Host write attempted while the command is in EXEC must be refused.
    start_cmd(3'b110, 3'd3, 3'd0, 3'd7, 1'b0);
    @(posedge clk); #1;
    chk("exec_alu_a_held", alu_a, 16'h000C);
    chk("exec_alu_opc", alu_opc, 3'b110);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'd3;
    bus.wr_data = 16'hBEEF;
    #1;
    chk("wr_err_busy", bus.wr_err, 1'b1);
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    finish_cmd(3, lat, oe);
    chk("busy_latency", lat, 3);
    chk("busy_result", bus.result, 16'h000C);
    chk("wr_err_idle", bus.wr_err, 1'b0);
    run_cmd("r3_kept", 3'b110, 3'd3, 3'd0, 3'd7, 1'b0);
    chk("r3_kept_val", bus.result, 16'h000C);

    // Host write on the same edge as the accepted command reaches FETCH.
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'd1;
    bus.wr_data = 16'h0030;
    start_cmd(3'b110, 3'd1, 3'd0, 3'd7, 1'b0);
    bus.wr_en = 1'b0;
    finish_cmd(1, lat, oe);
    chk("same_edge_lat", lat, 3);
    chk("same_edge_val", bus.result, 16'h0030);

    run_cmd("self1", 3'b010, 3'd2, 3'd2, 3'd2, 1'b0);
    chk("self1_val", bus.result, 16'h0002);
    run_cmd("self2", 3'b010, 3'd2, 3'd2, 3'd2, 1'b0);
    chk("self2_val", bus.result, 16'h0004);

    run_cmd("wb_r0", 3'b001, 3'd2, 3'd0, 3'd0, 1'b0);
    chk_flags("wb_r0", 16'h0005, 1'b0, 1'b0, 1'b0);
    wr_reg(3'd0, 16'h0055);
    run_cmd("r0_read", 3'b110, 3'd0, 3'd0, 3'd7, 1'b0);
    chk_flags("r0_read", 16'h0000, 1'b1, 1'b0, 1'b0);

    wr_reg(3'd5, 16'h0006);
    wr_reg(3'd6, 16'h000A);
    run_cmd("avg", 3'b011, 3'd5, 3'd6, 3'd7, 1'b0);
    chk("avg_val", bus.result, 16'h0008);
    run_cmd("and", 3'b100, 3'd5, 3'd6, 3'd7, 1'b0);
    chk("and_val", bus.result, 16'h0002);
    run_cmd("or", 3'b101, 3'd5, 3'd6, 3'd7, 1'b0);
    chk("or_val", bus.result, 16'h000E);

    run_cmd("neg30", 3'b000, 3'd1, 3'd0, 3'd7, 1'b0);
    chk_flags("neg30", 16'hFFD0, 1'b0, 1'b1, 1'b0);

    // Abort an add in EXEC with an asynchronous reset.
    start_cmd(3'b010, 3'd1, 3'd2, 3'd3, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    chk("abort_ready", bus.cmd_ready, 1'b1);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_alu_a", alu_a, 16'h0000);
    chk_flags("abort", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_ready_rel", bus.cmd_ready, 1'b1);
    run_cmd("abort_r3", 3'b110, 3'd3, 3'd0, 3'd7, 1'b0);
    chk("abort_r3_val", bus.result, 16'h0000);
    run_cmd("abort_r1", 3'b001, 3'd1, 3'd0, 3'd7, 1'b0);
    chk("abort_r1_val", bus.result, 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
